// File: rtl/detector_jogada_if.sv
// Button-play detector bus: raw button inputs and enable in, validated play and debug state out.
// The DUT takes the slave modport; the driving side (bench or parent) takes master.
interface detector_jogada_if;
  logic [3:0] botoes;
  logic       habilita;
  logic       jogada_feita;
  logic [3:0] jogada;
  logic       erro_multiplo;
  logic [3:0] db_estado;

  modport master (
    output botoes, habilita,
    input  jogada_feita, jogada, erro_multiplo, db_estado
  );

  modport slave (
    input  botoes, habilita,
    output jogada_feita, jogada, erro_multiplo, db_estado
  );
endinterface

// File: rtl/detector_jogada.sv
// Debounces 4 raw buttons and reports one play per full press/release; no backpressure.
// Latency: play pulse in the cycle after edge E0+DEBOUNCE+2 for buttons stable from edge E0.
module detector_jogada #(
  parameter int DEBOUNCE = 4
) (
  input  logic               clock,
  input  logic               reset,
  detector_jogada_if.slave   bus
);
  localparam int            CW      = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE - 1);

  typedef enum logic [1:0] {
    ESPERA         = 2'd0,
    FILTRA         = 2'd1,
    VALIDA         = 2'd2,
    AGUARDA_SOLTAR = 2'd3
  } estado_t;

  logic [3:0]    sinc_meta;
  logic [3:0]    sinc;
  estado_t       estado;
  estado_t       prox_estado;
  logic [3:0]    candidato;
  logic [3:0]    prox_candidato;
  logic [CW-1:0] cnt;
  logic [CW-1:0] prox_cnt;
  logic          valida_agora;
  logic          multiplo;
  logic [3:0]    jogada_r;
  logic          jogada_feita_r;
  logic          erro_r;

  always_ff @(posedge clock) begin
    if (reset) begin
      sinc_meta <= 4'b0000;
      sinc      <= 4'b0000;
    end else begin
      sinc_meta <= bus.botoes;
      sinc      <= sinc_meta;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      estado    <= ESPERA;
      candidato <= 4'b0000;
      cnt       <= '0;
    end else begin
      estado    <= prox_estado;
      candidato <= prox_candidato;
      cnt       <= prox_cnt;
    end
  end

  always_comb begin
    prox_estado    = estado;
    prox_candidato = candidato;
    prox_cnt       = cnt;
    valida_agora   = 1'b0;
    case (estado)
      ESPERA: begin
        if (sinc != 4'b0000) begin
          prox_estado    = FILTRA;
          prox_candidato = sinc;
          prox_cnt       = '0;
        end
      end
      FILTRA: begin
        if (sinc == 4'b0000) begin
          prox_estado = ESPERA;
          prox_cnt    = '0;
        end else if (sinc != candidato) begin
          prox_candidato = sinc;
          prox_cnt       = '0;
        end else if (cnt >= CNT_MAX) begin
          prox_estado  = VALIDA;
          prox_cnt     = '0;
          valida_agora = 1'b1;
        end else begin
          prox_cnt = cnt + 1'b1;
        end
      end
      VALIDA: begin
        prox_estado = AGUARDA_SOLTAR;
        prox_cnt    = '0;
      end
      AGUARDA_SOLTAR: begin
        // Any activity restarts the release window, so bounces never re-arm a play.
        if (sinc != 4'b0000) begin
          prox_cnt = '0;
        end else if (cnt >= CNT_MAX) begin
          prox_estado = ESPERA;
          prox_cnt    = '0;
        end else begin
          prox_cnt = cnt + 1'b1;
        end
      end
      default: begin
        prox_estado = ESPERA;
        prox_cnt    = '0;
      end
    endcase
  end

  // Candidate is never zero at validation, so a nonzero x&(x-1) means two or more buttons.
  assign multiplo = |(candidato & (candidato - 4'd1));

  always_ff @(posedge clock) begin
    if (reset) begin
      jogada_r       <= 4'b0000;
      jogada_feita_r <= 1'b0;
      erro_r         <= 1'b0;
    end else begin
      jogada_feita_r <= 1'b0;
      erro_r         <= 1'b0;
      if (valida_agora && bus.habilita) begin
        if (multiplo) begin
          erro_r <= 1'b1;
        end else begin
          jogada_r       <= candidato;
          jogada_feita_r <= 1'b1;
        end
      end
    end
  end

  assign bus.jogada        = jogada_r;
  assign bus.jogada_feita  = jogada_feita_r;
  assign bus.erro_multiplo = erro_r;
  assign bus.db_estado     = {2'b00, estado};
endmodule

// File: doc/detector_jogada.md
DETECTOR_JOGADA -- requirements
Module: detector_jogada

Interface
REQ-001 The block SHALL have one clock and a reset that is synchronous and active-high, with ports named clock and reset.
REQ-002 Parameter DEBOUNCE, default 4, SHALL set the number of consecutive stable sync cycles required; legal range 2..65535; counter width SHALL be clog2(DEBOUNCE).
REQ-003 clock  input  1  system clock, all registers on rising edge.
REQ-004 reset  input  1  synchronous active-high reset.
REQ-005 botoes  input  4  raw, asynchronous, bouncing buttons, active-high.
REQ-006 habilita  input  1  plays accepted only when 1; sampled on the validation edge.
REQ-007 jogada_feita  output  1  registered single-cycle pulse marking a valid play.
REQ-008 jogada  output  4  registered one-hot code of the last valid play, held until the next valid play.
REQ-009 erro_multiplo  output  1  registered single-cycle pulse: more than one button stable at validation.
REQ-010 db_estado  output  4  current FSM state code, for the hexa7seg display.

Function
REQ-011 botoes SHALL pass through a 2-FF synchronizer per bit; its output vector is "sinc".
REQ-012 FSM states and codes SHALL be ESPERA=0, FILTRA=1, VALIDA=2, AGUARDA_SOLTAR=3; other codes SHALL go to ESPERA on the next edge.
REQ-013 In ESPERA: sinc=0 -> stay; sinc nonzero -> FILTRA, capture sinc into "candidato", counter=0.
REQ-014 In FILTRA: sinc=candidato and counter<DEBOUNCE-1 -> counter+1.
REQ-015 In FILTRA: sinc nonzero and different from candidato -> recapture candidato, counter=0, stay in FILTRA.
REQ-016 In FILTRA: sinc=0 -> ESPERA, no output activity.
REQ-017 In FILTRA: sinc=candidato and counter=DEBOUNCE-1 -> VALIDA; at this same edge the outputs SHALL update per REQ-018..020.
REQ-018 Validation edge, habilita=1 and candidato one-hot: jogada<=candidato, jogada_feita<=1.
REQ-019 Validation edge, habilita=1 and candidato has >=2 bits set: erro_multiplo<=1, jogada unchanged.
REQ-020 Validation edge, habilita=0: no pulse, jogada unchanged; the press SHALL still be consumed.
REQ-021 VALIDA SHALL last exactly one cycle and then go unconditionally to AGUARDA_SOLTAR; jogada_feita and erro_multiplo SHALL return to 0 at the next edge.
REQ-022 In AGUARDA_SOLTAR: counter counts consecutive cycles with sinc=0; any nonzero sinc clears it; counter=DEBOUNCE-1 with sinc=0 -> ESPERA.
REQ-023 Presses or bounces during AGUARDA_SOLTAR SHALL never produce a play; each play requires a full release.
REQ-024 Latency: with botoes held constant from edge E0, jogada_feita SHALL be high in the cycle after edge E0+DEBOUNCE+2 (i.e. the (DEBOUNCE+3)-th edge counting E0 as the first), for exactly one cycle.
REQ-025 jogada_feita and erro_multiplo SHALL never be high in the same cycle.
REQ-026 Counter arithmetic SHALL saturate and never wrap.

Reset
REQ-027 When reset=1 at an edge: state=ESPERA, synchronizers=0, candidato=0, counter=0, jogada=0000, jogada_feita=0, erro_multiplo=0, db_estado=0.
REQ-028 Reset SHALL have priority over all other inputs.
REQ-029 A button still held when reset is released SHALL be treated as a new press and produce a play after the full REQ-024 latency.

Verification (DEBOUNCE=4)
REQ-030 Reset, habilita=1, botoes=0100 from E0 and held -> jogada_feita=1 exactly in the cycle after E6, jogada=0100, db_estado sequence 0,1,1,1,1,2,3.
REQ-031 botoes=0010 for 2 cycles, 0000 for 1 cycle, then 0010 held -> exactly one pulse, timed from the start of the final stable press; jogada=0010.
REQ-032 botoes=1001 held -> erro_multiplo one-cycle pulse, no jogada_feita, jogada keeps its prior value.
REQ-033 habilita=0 on the validation edge with botoes=0001 -> no pulse, FSM reaches 3; after release it returns to 0, and the next press with habilita=1 produces jogada=0001.
REQ-034 Play 1000 validated, then 1000 released for 2 cycles and re-pressed -> no second pulse; full release for >=6 cycles followed by a press -> second pulse.
REQ-035 reset asserted while in FILTRA with 0100 held, then released -> outputs 0 during reset, then one pulse with the full REQ-024 latency after release.
